rom_prefetch_ctrl: RTL and testbench

ROM_PREFETCH_CTRL -- requirements
Module: rom_prefetch_ctrl

---
 rtl/rom_prefetch_ctrl.sv | 115 +++++++++++
 tb/tb_rom_prefetch_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_prefetch_ctrl.sv
// rom_prefetch_ctrl: CPU-side controller for a 1-cycle synchronous ROM.
// Serves 16-bit word reads and keeps a one-word sequential prefetch buffer.
// A read that hits the buffer completes in one cycle. A miss goes through
// FETCH/CAPT. Writes are rejected with a bus error. After every read the
// next word is prefetched.
module rom_prefetch_ctrl #(
    parameter int ADDR_WIDTH  = 12,
    parameter int PREFETCH_EN = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpu_rd_ena,
    input  logic                  cpu_wr_ena,
    input  logic [ADDR_WIDTH-1:1] cpu_address,
    output logic [15:0]           cpu_rd_data,
    output logic                  cpu_data_ack,
    output logic                  cpu_bus_err,
    output logic [ADDR_WIDTH-2:0] rom_address,
    input  logic [15:0]           rom_q
);

    localparam int WW = ADDR_WIDTH - 1;
    localparam logic [WW-1:0] WORD_ONE = WW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CAPT  = 3'd2,
        PREF  = 3'd3,
        PCAPT = 3'd4,
        WERR  = 3'd5
    } state_t;

    state_t          state;
    logic [WW-1:0]   addr_r;
    logic [WW-1:0]   pf_addr;
    logic [15:0]     pf_data;
    logic            pf_valid;
    logic            pf_hit;

    assign rom_address = addr_r;

    // Prefetch buffer hit for the request currently presented by the CPU
    always_comb begin
        pf_hit = 1'b0;
        if ((PREFETCH_EN != 0) && pf_valid && (cpu_address == pf_addr))
            pf_hit = 1'b1;
    end

    // Request sequencing, ROM addressing, prefetch buffer and registered CPU outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            addr_r       <= '0;
            pf_addr      <= '0;
            pf_data      <= '0;
            pf_valid     <= 1'b0;
            cpu_rd_data  <= '0;
            cpu_data_ack <= 1'b0;
            cpu_bus_err  <= 1'b0;
        end else begin
            cpu_data_ack <= 1'b0;
            cpu_bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // While an ack is still visible the CPU is still holding the request
                    // it has just been given. Resampling it now would serve it twice.
                    if (!cpu_data_ack) begin
                        if (cpu_wr_ena) begin
                            cpu_data_ack <= 1'b1;
                            cpu_bus_err  <= 1'b1;
                            state        <= WERR;
                        end else if (cpu_rd_ena) begin
                            if (pf_hit) begin
                                cpu_rd_data  <= pf_data;
                                cpu_data_ack <= 1'b1;
                                addr_r       <= cpu_address + WORD_ONE;
                                state        <= PREF;
                            end else begin
                                addr_r <= cpu_address;
                                state  <= FETCH;
                            end
                        end
                    end
                end
                FETCH: begin
                    state <= CAPT;
                end
                CAPT: begin
                    cpu_rd_data  <= rom_q;
                    cpu_data_ack <= 1'b1;
                    addr_r       <= addr_r + WORD_ONE;
                    pf_valid     <= 1'b0;
                    state        <= (PREFETCH_EN != 0) ? PREF : IDLE;
                end
                PREF: begin
                    state <= PCAPT;
                end
                PCAPT: begin
                    pf_data  <= rom_q;
                    pf_addr  <= addr_r;
                    pf_valid <= 1'b1;
                    state    <= IDLE;
                end
                WERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_prefetch_ctrl.sv
// Testbench for rom_prefetch_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level model of the prefetch buffer.
module tb_rom_prefetch_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        cpu_rd_ena = 1'b0;
    logic        cpu_wr_ena = 1'b0;
    logic [11:1] cpu_address = '0;
    logic [15:0] cpu_rd_data;
    logic        cpu_data_ack;
    logic        cpu_bus_err;
    logic [10:0] rom_address;
    logic [15:0] rom_q;

    logic [15:0] rom_mem [0:2047];

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model: prefetch buffer contents, last data, ROM address, busy tail
    bit          m_pf_valid;
    logic [10:0] m_pf_addr;
    logic [10:0] m_rom_addr;
    logic [15:0] m_rd_data;
    int          m_tail;

    rom_prefetch_ctrl #(.ADDR_WIDTH(12), .PREFETCH_EN(1)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_rd_ena  (cpu_rd_ena),
        .cpu_wr_ena  (cpu_wr_ena),
        .cpu_address (cpu_address),
        .cpu_rd_data (cpu_rd_data),
        .cpu_data_ack(cpu_data_ack),
        .cpu_bus_err (cpu_bus_err),
        .rom_address (rom_address),
        .rom_q       (rom_q)
    );

    always #5 clock = ~clock;

    // External ROM: one-cycle synchronous read
    always @(posedge clock) rom_q <= rom_mem[rom_address];

    task automatic model_reset();
        m_pf_valid = 0;
        m_pf_addr  = '0;
        m_rom_addr = '0;
        m_rd_data  = '0;
        m_tail     = 0;
    endtask

    // Expected outcome of one request issued after `gap` idle cycles
    task automatic model_txn(input bit wr, input logic [10:0] a, input int gap,
                             output int lat, output logic [15:0] d, output logic e,
                             output logic [10:0] ra);
        int  wait_c;
        bit  hit;
        wait_c = (m_tail > gap) ? (m_tail - gap) : 0;
        if (wr) begin
            lat    = wait_c + 1;
            d      = m_rd_data;
            e      = 1'b1;
            ra     = m_rom_addr;
            m_tail = 1;
        end else begin
            hit        = m_pf_valid && (a == m_pf_addr);
            lat        = wait_c + (hit ? 1 : 3);
            d          = rom_mem[a];
            e          = 1'b0;
            m_rom_addr = a + 11'd1;
            ra         = m_rom_addr;
            m_pf_valid = 1;
            m_pf_addr  = a + 11'd1;
            m_rd_data  = d;
            m_tail     = 2;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            m_tail = (m_tail > 0) ? m_tail - 1 : 0;
        end
    endtask

    // Drive one request and capture what the DUT returns on its ack (lat=-1 on timeout)
    task automatic run_txn(input bit wr, input bit rd, input logic [10:0] a, input int gap,
                           output int lat, output logic [15:0] d, output logic e,
                           output logic [10:0] ra);
        cpu_rd_ena = 1'b0;
        cpu_wr_ena = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clock); #1;
        end
        cpu_address = a;
        cpu_wr_ena  = wr;
        cpu_rd_ena  = rd;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (cpu_data_ack) begin
                lat = i;
                break;
            end
        end
        d  = cpu_rd_data;
        e  = cpu_bus_err;
        ra = rom_address;
        cpu_rd_ena = 1'b0;
        cpu_wr_ena = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        cpu_address = 11'h010;
        cpu_rd_ena  = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_tests++; if (cpu_data_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b want=0", cpu_data_ack); end
        n_tests++; if (cpu_bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b want=0", cpu_bus_err); end
        n_tests++; if (cpu_rd_data !== 16'h0) begin n_fail++; $display("FAIL reset_rd_data got=%h want=0000", cpu_rd_data); end
        n_tests++; if (rom_address !== 11'h0) begin n_fail++; $display("FAIL reset_rom_address got=%h want=000", rom_address); end
        n_tests++; if (dut.pf_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pf_valid got=%b want=0", dut.pf_valid); end
        cpu_rd_ena = 1'b0;
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        model_reset();
    endtask

    task automatic test_miss_prefetch();
        int lat, elat; logic [15:0] d, ed; logic e, ee; logic [10:0] ra, era;
        model_txn(0, 11'h010, 0, elat, ed, ee, era);
        run_txn(0, 1, 11'h010, 0, lat, d, e, ra);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL miss010_latency got=%0d want=3", lat); end
        n_tests++; if (d !== 16'hA5A5) begin n_fail++; $display("FAIL miss010_data got=%h want=a5a5", d); end
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL miss010_bus_err got=%b want=0", e); end
        n_tests++; if (ra !== 11'h011) begin n_fail++; $display("FAIL miss010_pref_addr got=%h want=011", ra); end
        idle_cycles(1);
        n_tests++; if (cpu_data_ack !== 1'b0) begin n_fail++; $display("FAIL ack_single_cycle got=%b want=0", cpu_data_ack); end
        n_tests++; if (cpu_rd_data !== 16'hA5A5) begin n_fail++; $display("FAIL rd_data_hold got=%h want=a5a5", cpu_rd_data); end
        idle_cycles(1);
        n_tests++; if (dut.pf_valid !== 1'b1) begin n_fail++; $display("FAIL pcapt_pf_valid got=%b want=1", dut.pf_valid); end
        n_tests++; if (dut.pf_data !== 16'h1234) begin n_fail++; $display("FAIL pcapt_pf_data got=%h want=1234", dut.pf_data); end
    endtask

    task automatic test_hit();
        int lat, elat; logic [15:0] d, ed; logic e, ee; logic [10:0] ra, era;
        model_txn(0, 11'h011, 0, elat, ed, ee, era);
        run_txn(0, 1, 11'h011, 0, lat, d, e, ra);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL hit011_latency got=%0d want=1", lat); end
        n_tests++; if (d !== 16'h1234) begin n_fail++; $display("FAIL hit011_data got=%h want=1234", d); end
        n_tests++; if (ra !== 11'h012) begin n_fail++; $display("FAIL hit011_pref_addr got=%h want=012", ra); end
    endtask

    task automatic test_miss_invalidates();
        int lat, elat; logic [15:0] d, ed; logic e, ee; logic [10:0] ra, era;
        model_txn(0, 11'h020, 3, elat, ed, ee, era);
        run_txn(0, 1, 11'h020, 3, lat, d, e, ra);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL miss020_latency got=%0d want=3", lat); end
        n_tests++; if (d !== 16'hBEEF) begin n_fail++; $display("FAIL miss020_data got=%h want=beef", d); end
        model_txn(0, 11'h012, 3, elat, ed, ee, era);
        run_txn(0, 1, 11'h012, 3, lat, d, e, ra);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL stale012_latency got=%0d want=3", lat); end
        n_tests++; if (d !== 16'h5A5A) begin n_fail++; $display("FAIL stale012_data got=%h want=5a5a", d); end
    endtask

    task automatic test_write_reject();
        int lat, elat; logic [15:0] d, ed; logic e, ee; logic [10:0] ra, era;
        model_txn(1, 11'h005, 3, elat, ed, ee, era);
        run_txn(1, 1, 11'h005, 3, lat, d, e, ra);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL wr005_latency got=%0d want=1", lat); end
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL wr005_bus_err got=%b want=1", e); end
        n_tests++; if (ra !== 11'h013) begin n_fail++; $display("FAIL wr005_rom_address got=%h want=013", ra); end
        n_tests++; if (d !== 16'h5A5A) begin n_fail++; $display("FAIL wr005_rd_data_hold got=%h want=5a5a", d); end
        // Request raised during WERR stays pending; buffer must still hold word 0x013
        model_txn(0, 11'h013, 0, elat, ed, ee, era);
        run_txn(0, 1, 11'h013, 0, lat, d, e, ra);
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL after_wr_hit013_latency got=%0d want=2", lat); end
        n_tests++; if (d !== 16'h1313) begin n_fail++; $display("FAIL after_wr_hit013_data got=%h want=1313", d); end
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL after_wr_hit013_bus_err got=%b want=0", e); end
    endtask

    task automatic test_wrap();
        int lat, elat; logic [15:0] d, ed; logic e, ee; logic [10:0] ra, era;
        model_txn(0, 11'h7FF, 3, elat, ed, ee, era);
        run_txn(0, 1, 11'h7FF, 3, lat, d, e, ra);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL wrap7ff_latency got=%0d want=3", lat); end
        n_tests++; if (d !== 16'h7FF7) begin n_fail++; $display("FAIL wrap7ff_data got=%h want=7ff7", d); end
        n_tests++; if (ra !== 11'h000) begin n_fail++; $display("FAIL wrap7ff_pref_addr got=%h want=000", ra); end
        model_txn(0, 11'h000, 3, elat, ed, ee, era);
        run_txn(0, 1, 11'h000, 3, lat, d, e, ra);
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL hit000_latency got=%0d want=1", lat); end
        n_tests++; if (d !== 16'h0F0F) begin n_fail++; $display("FAIL hit000_data got=%h want=0f0f", d); end
    endtask

    task automatic test_reset_mid_capt();
        int lat, elat; logic [15:0] d, ed; logic e, ee; logic [10:0] ra, era;
        idle_cycles(3);
        cpu_address = 11'h040;
        cpu_rd_ena  = 1'b1;
        @(posedge clock);   // request sampled, miss
        @(posedge clock);   // FETCH -> CAPT
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (cpu_data_ack !== 1'b0) begin n_fail++; $display("FAIL capt_reset_ack got=%b want=0", cpu_data_ack); end
        n_tests++; if (cpu_rd_data !== 16'h0) begin n_fail++; $display("FAIL capt_reset_rd_data got=%h want=0000", cpu_rd_data); end
        n_tests++; if (rom_address !== 11'h0) begin n_fail++; $display("FAIL capt_reset_rom_address got=%h want=000", rom_address); end
        n_tests++; if (dut.pf_valid !== 1'b0) begin n_fail++; $display("FAIL capt_reset_pf_valid got=%b want=0", dut.pf_valid); end
        cpu_rd_ena = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_tests++; if (cpu_data_ack !== 1'b0) begin n_fail++; $display("FAIL capt_reset_no_ack got=%b want=0", cpu_data_ack); end
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        model_reset();
        model_txn(0, 11'h040, 0, elat, ed, ee, era);
        run_txn(0, 1, 11'h040, 0, lat, d, e, ra);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL reissue040_latency got=%0d want=3", lat); end
        n_tests++; if (d !== 16'h4040) begin n_fail++; $display("FAIL reissue040_data got=%h want=4040", d); end
    endtask

    task automatic test_back_to_back();
        int lat, elat; logic [15:0] d, ed; logic e, ee; logic [10:0] ra, era;
        logic [10:0] seq_a [4];
        bit          seq_w [4];
        seq_a = '{11'h041, 11'h050, 11'h066, 11'h051};
        seq_w = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            model_txn(seq_w[i], seq_a[i], 0, elat, ed, ee, era);
            run_txn(seq_w[i], !seq_w[i], seq_a[i], 0, lat, d, e, ra);
            n_tests++; if (lat !== elat) begin n_fail++; $display("FAIL b2b%0d_latency got=%0d want=%0d", i, lat, elat); end
            n_tests++; if (d !== ed) begin n_fail++; $display("FAIL b2b%0d_data got=%h want=%h", i, d, ed); end
            n_tests++; if (e !== ee) begin n_fail++; $display("FAIL b2b%0d_bus_err got=%b want=%b", i, e, ee); end
        end
    endtask

    task automatic test_random();
        int lat, elat; logic [15:0] d, ed; logic e, ee; logic [10:0] ra, era;
        bit wr, rd; logic [10:0] a; int gap;
        for (int i = 0; i < 60; i++) begin
            wr  = ($urandom_range(0, 4) == 0);
            rd  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            a   = ($urandom_range(0, 1) == 1) ? m_pf_addr : 11'($urandom);
            gap = $urandom_range(0, 3);
            model_txn(wr, a, gap, elat, ed, ee, era);
            run_txn(wr, rd, a, gap, lat, d, e, ra);
            n_tests++; if (lat !== elat) begin n_fail++; $display("FAIL rnd%0d_latency addr=%h got=%0d want=%0d", i, a, lat, elat); end
            n_tests++; if (d !== ed) begin n_fail++; $display("FAIL rnd%0d_data addr=%h got=%h want=%h", i, a, d, ed); end
            n_tests++; if (e !== ee) begin n_fail++; $display("FAIL rnd%0d_bus_err got=%b want=%b", i, e, ee); end
            n_tests++; if (ra !== era) begin n_fail++; $display("FAIL rnd%0d_rom_address got=%h want=%h", i, ra, era); end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom_mem[i] = 16'($urandom);
        rom_mem[11'h000] = 16'h0F0F;
        rom_mem[11'h010] = 16'hA5A5;
        rom_mem[11'h011] = 16'h1234;
        rom_mem[11'h012] = 16'h5A5A;
        rom_mem[11'h013] = 16'h1313;
        rom_mem[11'h020] = 16'hBEEF;
        rom_mem[11'h040] = 16'h4040;
        rom_mem[11'h7FF] = 16'h7FF7;
        model_reset();
        test_reset();
        test_miss_prefetch();
        test_hit();
        test_miss_invalidates();
        test_write_reject();
        test_wrap();
        test_reset_mid_capt();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
